// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle main controller: opcodes, state
// encoding, datapath select encodings and the decoded control bundle.
package mc_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0D;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10,
    ALU_OR    = 2'b11
  } aluop_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pcsrc_t;

  typedef struct packed {
    logic   pcwrite;
    logic   pcwritecond;
    logic   iord;
    logic   memread;
    logic   memwrite;
    logic   irwrite;
    logic   memtoreg;
    logic   regdst;
    logic   regwrite;
    logic   alusrca;
    srcb_t  alusrcb;
    aluop_t aluop;
    pcsrc_t pcsrc;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle: IR opcode / status in, selects and enables out.
interface mc_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             zero;
    logic             mem_ready;
    logic             pcwrite;
    logic             pcwritecond;
    logic             iord;
    logic             memread;
    logic             memwrite;
    logic             irwrite;
    logic             memtoreg;
    logic             regdst;
    logic             regwrite;
    logic             alusrca;
    logic [1:0]       alusrcb;
    logic [1:0]       aluop;
    logic [1:0]       pcsrc;
    logic [CNT_W-1:0] instret;
    logic             illegal_op;

    modport master (
        input  opcode, zero, mem_ready,
        output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc,
               instret, illegal_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
               memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc,
               instret, illegal_op
    );
endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// State-to-control decoder; FETCH additionally gates the IR/PC loads on the
// effective memory-ready so a stalled fetch never commits.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.memread = 1'b1;
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.aluop   = ALU_ADD;
                ctrl.irwrite = ready;
                ctrl.pcwrite = ready;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMM_SH2;
                ctrl.aluop   = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl.iord    = 1'b1;
                ctrl.memread = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_REG;
                ctrl.aluop   = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca     = 1'b1;
                ctrl.alusrcb     = SRCB_REG;
                ctrl.aluop       = ALU_SUB;
                ctrl.pcwritecond = 1'b1;
                ctrl.pcsrc       = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PC_JUMP;
            end
            S_IEXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
            end
            S_IWB: begin
                ctrl.regwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main controller: state register, next-state logic and the
// retired-instruction counter. Define MC_ILLEGAL_TRAP_EN to trap unknown opcodes.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MEM_WAIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    mc_ctrl_fsm_if.master     bus
);

    state_t           state;
    logic [CNT_W-1:0] instret;
    logic             ready;
    ctrl_t            ctrl;

    assign ready = (MEM_WAIT != 0) ? bus.mem_ready : 1'b1;

    mc_ctrl_decode u_decode (
        .state  (state),
        .opcode (bus.opcode),
        .ready  (ready),
        .ctrl   (ctrl)
    );

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal <= 1'b0;
        end else if (state == S_DECODE &&
                     !(bus.opcode inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_J,
                                          OP_ADDI, OP_ORI})) begin
            illegal <= 1'b1;
        end
    end

    assign bus.illegal_op = illegal;
`else
    assign bus.illegal_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            case (state)
                S_FETCH:  if (ready) state <= S_DECODE;
                S_DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW:    state <= S_MEMADR;
                        OP_R:            state <= S_EXEC;
                        OP_BEQ:          state <= S_BRANCH;
                        OP_J:            state <= S_JUMP;
                        OP_ADDI, OP_ORI: state <= S_IEXEC;
                        default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                            state <= S_TRAP;
`else
                            state   <= S_FETCH;
                            instret <= instret + CNT_W'(1);
`endif
                        end
                    endcase
                end
                S_MEMADR: state <= (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (ready) state <= S_MEMWB;
                S_MEMWR: begin
                    if (ready) begin
                        state   <= S_FETCH;
                        instret <= instret + CNT_W'(1);
                    end
                end
                S_EXEC:   state <= S_ALUWB;
                S_IEXEC:  state <= S_IWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_IWB: begin
                    state   <= S_FETCH;
                    instret <= instret + CNT_W'(1);
                end
`ifdef MC_ILLEGAL_TRAP_EN
                S_TRAP:   state <= S_TRAP;
`endif
                default:  state <= S_FETCH;
            endcase
        end
    end

    assign bus.pcwrite     = ctrl.pcwrite;
    assign bus.pcwritecond = ctrl.pcwritecond;
    assign bus.iord        = ctrl.iord;
    assign bus.memread     = ctrl.memread;
    assign bus.memwrite    = ctrl.memwrite;
    assign bus.irwrite     = ctrl.irwrite;
    assign bus.memtoreg    = ctrl.memtoreg;
    assign bus.regdst      = ctrl.regdst;
    assign bus.regwrite    = ctrl.regwrite;
    assign bus.alusrca     = ctrl.alusrca;
    assign bus.alusrcb     = ctrl.alusrcb;
    assign bus.aluop       = ctrl.aluop;
    assign bus.pcsrc       = ctrl.pcsrc;
    assign bus.instret     = instret;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: per-instruction cycle sequences are
// expanded into expected control words, a negedge monitor compares them.
module tb_mc_ctrl_fsm;

    localparam int CW = 4;

    localparam logic [5:0] R_OP = 6'h00, LW_OP = 6'h23, SW_OP = 6'h2B,
                           BEQ_OP = 6'h04, J_OP = 6'h02, ADDI_OP = 6'h08,
                           ORI_OP = 6'h0D, BAD_OP = 6'h3F;

    typedef struct packed {
        logic [15:0]   ctl;
        logic [CW-1:0] cnt;
        logic          ill;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_ctrl_fsm_if #(.CNT_W(CW)) bus ();

    mc_ctrl_fsm #(.CNT_W(CW), .MEM_WAIT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t          expq[$];
    logic [CW-1:0] cnt_m = '0;
    logic          ill_m = 1'b0;
    int            checks = 0;
    int            errors = 0;

    // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,alusrca,alusrcb,aluop,pcsrc}
    function automatic logic [15:0] c(input bit pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa,
                                       input bit [1:0] b, op, ps);
        return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, b, op, ps};
    endfunction

    logic [15:0] FW, FG, DEC, ADR, RD, WBM, WR, EXE, WBA, BR, JMP, IADD, IOR, WBI, NONE;
    initial begin
        FW   = c(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00);
        FG   = c(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00);
        DEC  = c(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00);
        ADR  = c(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
        RD   = c(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00);
        WBM  = c(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00);
        WR   = c(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00);
        EXE  = c(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00);
        WBA  = c(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00);
        BR   = c(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01);
        JMP  = c(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10);
        IADD = c(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00);
        IOR  = c(0,0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00);
        WBI  = c(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00);
        NONE = '0;
    end

    // One clock cycle: drive inputs, record what the outputs must be this cycle.
    task automatic cyc(input logic [15:0] ctl, input logic rdy, input bit do_rst);
        bus.mem_ready = rdy;
        bus.zero      = 1'($urandom);
        rst           = do_rst;
        expq.push_back('{ctl: ctl, cnt: cnt_m, ill: ill_m});
        @(posedge clk);
        #1;
        rst = 1'b0;
        if (do_rst) begin
            cnt_m = '0;
            ill_m = 1'b0;
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    task automatic instr(input logic [5:0] op, input int fs, input int ms);
        bit retire;
        retire = 1'b1;
        bus.opcode = op;
        repeat (fs) cyc(FW, 1'b0, 0);
        cyc(FG, 1'b1, 0);
        cyc(DEC, rnd(), 0);
        case (op)
            LW_OP: begin
                cyc(ADR, rnd(), 0);
                repeat (ms) cyc(RD, 1'b0, 0);
                cyc(RD, 1'b1, 0);
                cyc(WBM, rnd(), 0);
            end
            SW_OP: begin
                cyc(ADR, rnd(), 0);
                repeat (ms) cyc(WR, 1'b0, 0);
                cyc(WR, 1'b1, 0);
            end
            R_OP:    begin cyc(EXE, rnd(), 0); cyc(WBA, rnd(), 0); end
            BEQ_OP:  cyc(BR, rnd(), 0);
            J_OP:    cyc(JMP, rnd(), 0);
            ADDI_OP: begin cyc(IADD, rnd(), 0); cyc(WBI, rnd(), 0); end
            ORI_OP:  begin cyc(IOR, rnd(), 0); cyc(WBI, rnd(), 0); end
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                ill_m  = 1'b1;
                retire = 1'b0;
                repeat (10) cyc(NONE, rnd(), 0);
`endif
            end
        endcase
        if (retire) cnt_m = cnt_m + 1'b1;
    endtask

    always @(negedge clk) begin
        obs_t e, g;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            g.ctl = {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
                     bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
                     bus.alusrcb, bus.aluop, bus.pcsrc};
            g.cnt = bus.instret;
            g.ill = bus.illegal_op;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL ctrl_vec t=%0t: got ctl=%b instret=%0d ill=%b, expected ctl=%b instret=%0d ill=%b",
                         $time, g.ctl, g.cnt, g.ill, e.ctl, e.cnt, e.ill);
            end
        end
    end

    logic [5:0] legal[7];
    initial begin
        legal = '{R_OP, LW_OP, SW_OP, BEQ_OP, J_OP, ADDI_OP, ORI_OP};
        bus.opcode = R_OP;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, with one stalled fetch.
        instr(LW_OP, 1, 2);
        instr(ADDI_OP, 0, 0);
        instr(ORI_OP, 0, 0);
        instr(R_OP, 0, 0);
        instr(BEQ_OP, 0, 0);
        instr(BEQ_OP, 0, 0);
        instr(SW_OP, 0, 1);

        // Reset while a store is stalled in its write cycle.
        bus.opcode = SW_OP;
        cyc(FG, 1'b1, 0);
        cyc(DEC, rnd(), 0);
        cyc(ADR, rnd(), 0);
        cyc(WR, 1'b0, 0);
        cyc(WR, 1'b0, 1);
        cyc(FW, 1'b0, 0);

        repeat (17) instr(J_OP, 0, 0);

        for (int i = 0; i < 40; i++)
            instr(legal[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 2));

        instr(BAD_OP, 0, 0);
`ifdef MC_ILLEGAL_TRAP_EN
        cyc(NONE, rnd(), 1);
`else
        instr(J_OP, 0, 0);
        cyc(FW, 1'b0, 1);
`endif
        cyc(FW, 1'b0, 0);

        repeat (2) @(posedge clk);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending entries, expected 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Multi-cycle main controller for the multi_core_cpu datapath.
- Decodes the latched instruction opcode and sequences the fetch/decode/execute/memory/writeback steps.
- Drives every datapath select and enable, including the ALU operand-B source select consumed by the operand muxes.
- Sits between the instruction register and the datapath muxes, register file and memory port; Moore outputs, one state per cycle.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- MEM_WAIT, 1, 1 = memory states stall until mem_ready; 0 = memory always completes in one cycle (mem_ready ignored).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  6  instr[31:26] from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access completes this cycle.
- pcwrite  output  1  unconditional PC load.
- pcwritecond  output  1  PC load if zero.
- iord  output  1  memory address source: 0 = PC, 1 = ALUOut.
- memread  output  1  memory read strobe.
- memwrite  output  1  memory write strobe.
- irwrite  output  1  instruction register load.
- memtoreg  output  1  register write data: 0 = ALUOut, 1 = MDR.
- regdst  output  1  destination register: 0 = rt, 1 = rd.
- regwrite  output  1  register file write enable.
- alusrca  output  1  ALU A: 0 = PC, 1 = register A.
- alusrcb  output  2  ALU B: 00 = regdata, 01 = const 4, 10 = sign-extended immediate, 11 = immediate<<2.
- aluop  output  2  00 = add, 01 = sub, 10 = funct-decoded, 11 = or.
- pcsrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- instret  output  CNT_W  retired-instruction count.
- illegal_op  output  1  sticky illegal-opcode flag (feature only; otherwise tied 0).

Behaviour:
- Opcodes: R=0x00, LW=0x23, SW=0x2B, BEQ=0x04, J=0x02, ADDI=0x08, ORI=0x0D.
- State register: 4 bits, encoded as follows:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, TRAP=12.
- Reset: rst high at a clock edge forces state=FETCH, instret=0, illegal_op=0. This is synchronous and aborts any in-progress instruction with no write.
- Outputs are combinational from state only. All enables are 0 and all selects are 0 unless listed below.
- FETCH: memread=1, alusrcb=01, aluop=00.
  - irwrite=1 and pcwrite=1 only when mem_ready=1 (or MEM_WAIT=0).
  - Then go to DECODE; otherwise stay in FETCH.
- DECODE: alusrcb=11, aluop=00. Next state by opcode:
  - LW/SW -> MEMADR; R -> EXEC; BEQ -> BRANCH; J -> JUMP; ADDI/ORI -> IEXEC.
  - Other opcodes -> see Optional Feature.
- MEMADR: alusrca=1, alusrcb=10, aluop=00. LW -> MEMRD, SW -> MEMWR.
- MEMRD: iord=1, memread=1. Stall until mem_ready, then -> MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0 -> FETCH; instret+1.
- MEMWR: iord=1, memwrite=1.
  - memwrite stays high through every stall cycle.
  - On mem_ready -> FETCH; instret+1.
- EXEC: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0 -> FETCH; instret+1.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsrc=01 -> FETCH; instret+1. PC loads only when zero=1.
- JUMP: pcwrite=1, pcsrc=10 -> FETCH; instret+1.
- IEXEC: alusrca=1, alusrcb=10; aluop=00 for ADDI, 11 for ORI -> IWB.
- IWB: regwrite=1, regdst=0, memtoreg=0 -> FETCH; instret+1.
- Opcode is sampled combinationally in DECODE, MEMADR and IEXEC. The IR holds it stable because irwrite is 0 outside FETCH.
- instret wraps modulo 2^CNT_W without a flag.
- Cycle counts with MEM_WAIT=0: LW=5, SW=4, R=4, ADDI/ORI=4, BEQ=3, J=3.
- An unreachable state encoding returns to FETCH on the next edge.

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
  - Defined: an unknown opcode in DECODE -> TRAP. TRAP asserts no enables and holds until rst. illegal_op is set on entry to TRAP and stays 1 until reset. instret is not incremented.
  - Undefined: an unknown opcode in DECODE -> FETCH as a NOP, with instret+1. TRAP is unused and illegal_op is constant 0.

Decomposition:
- Shared package mc_pkg holds:
  - the opcode constants;
  - the state encoding constants;
  - the alusrcb, aluop and pcsrc encodings.
- One natural sub-module: mc_ctrl_decode, a combinational state-to-output-vector decoder. The FSM top keeps the state register, next-state logic and counters.

Test Plan:
- Reset mid-MEMWR (memwrite=1), rst=1 for one edge -> next cycle state FETCH, memwrite=0, instret=0.
- LW (0x23), MEM_WAIT=1, mem_ready low 2 cycles in MEMRD -> memread held 3 cycles in MEMRD, regwrite=1 and memtoreg=1 in MEMWB, instret 0->1.
- ADDI (0x08) then ORI (0x0D) -> IEXEC shows alusrcb=10 with aluop=00, then 11; IWB shows regwrite=1 and regdst=0; instret=2 after 8 cycles (MEM_WAIT=0).
- R-type then BEQ with zero=0, then BEQ with zero=1 -> EXEC shows alusrcb=00 and aluop=10; the BRANCH cycle shows pcwritecond=1 and pcsrc=01 both times; instret=3.
- Opcode 0x3F -> with MC_ILLEGAL_TRAP_EN: TRAP entered, illegal_op=1, no enables for 10 cycles, instret unchanged. Without the macro: back to FETCH after 2 cycles, instret+1.
- CNT_W=4, 16 J instructions -> instret wraps 15->0; pcwrite=1 and pcsrc=10 in each JUMP cycle.
